// File: rtl/nmos_cnt_reg.sv
// Two-phase counter register: PHI2 stage computes load / set-clear / increment, PHI1 stage presents Q and CO.
// Optional decrement path and DEC port are compiled in when NMOS_CNT_DEC_EN is defined.
module nmos_cnt_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             main_clk,
  input  logic             R,
  input  logic             C1,
  input  logic             C2,
  inout  wire  [WIDTH-1:0] DB,
  input  logic             OE,
  input  logic             LD,
  input  logic             SC,
  input  logic             SE,
  input  logic             INC,
`ifdef NMOS_CNT_DEC_EN
  input  logic             DEC,
`endif
  output logic [WIDTH-1:0] Q,
  output logic             CO
);

  logic [WIDTH-1:0] r_p1_val;
  logic [WIDTH-1:0] r_p2_val;
  logic             r_p1_cy;
  logic             r_p2_cy;
  logic [WIDTH-1:0] w_nxt_val;
  logic             w_nxt_cy;
  logic [WIDTH:0]   w_inc;
`ifdef NMOS_CNT_DEC_EN
  logic [WIDTH:0]   w_dec;
`endif

  // Top bit of the widened sum/difference is the carry (all-ones wrap) or borrow (zero wrap).
  assign w_inc = {1'b0, r_p1_val} + {{WIDTH{1'b0}}, 1'b1};
`ifdef NMOS_CNT_DEC_EN
  assign w_dec = {1'b0, r_p1_val} - {{WIDTH{1'b0}}, 1'b1};
`endif

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch is inferred.
    w_nxt_val = r_p1_val;
    w_nxt_cy  = 1'b0;
    if (LD) begin
      w_nxt_val = DB;
    end else if (SC) begin
      w_nxt_val = (r_p1_val & ~DB) | ({WIDTH{SE}} & DB);
      w_nxt_cy  = r_p1_cy;
    end else if (INC) begin
      w_nxt_val = w_inc[WIDTH-1:0];
      w_nxt_cy  = w_inc[WIDTH];
`ifdef NMOS_CNT_DEC_EN
    end else if (DEC) begin
      w_nxt_val = w_dec[WIDTH-1:0];
      w_nxt_cy  = w_dec[WIDTH];
`endif
    end
  end

  always_ff @(posedge main_clk) begin
    if (R) begin
      r_p1_val <= RST_VAL;
      r_p1_cy  <= 1'b0;
      r_p2_val <= RST_VAL;
      r_p2_cy  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates make C1=C2=1 a clean swap of pre-edge values, never a fall-through.
      if (C1) begin
        r_p1_val <= r_p2_val;
        r_p1_cy  <= r_p2_cy;
      end
      if (C2) begin
        r_p2_val <= w_nxt_val;
        r_p2_cy  <= w_nxt_cy;
      end
    end
  end

  assign Q  = r_p1_val;
  assign CO = r_p1_cy;
  assign DB = OE ? r_p1_val : {WIDTH{1'bz}};

endmodule

// File: doc/nmos_cnt_reg.md
NMOS_CNT_REG -- requirements
Module: nmos_cnt_reg

Interface
REQ-001 Parameter WIDTH, default 8, register width in bits (1..32).
REQ-002 Parameter RST_VAL, default 0, WIDTH-bit value loaded by reset.
REQ-003 main_clk  in  1  simulation master clock; all state updates on its rising edge.
REQ-004 R  in  1  reset, synchronous, active-high.
REQ-005 C1  in  1  PHI1 phase qualifier, sampled on main_clk.
REQ-006 C2  in  1  PHI2 phase qualifier, sampled on main_clk.
REQ-007 DB  inout  WIDTH  data bus; driven by the block only when OE=1, else high-Z.
REQ-008 OE  in  1  bus output enable.
REQ-009 LD  in  1  parallel load from DB.
REQ-010 SC  in  1  bus-addressed set/clear strobe.
REQ-011 SE  in  1  set/clear value applied under SC.
REQ-012 INC  in  1  increment request.
REQ-013 DEC  in  1  decrement request (present only with NMOS_CNT_DEC_EN).
REQ-014 Q  out  WIDTH  register output (PHI1 stage).
REQ-015 CO  out  1  carry/borrow flag (PHI1 stage).

Function
REQ-016 Two internal stages SHALL exist: p2 (WIDTH bits + carry) written when C2=1, p1 (WIDTH bits + carry) written when C1=1.
REQ-017 On main_clk edge with C1=1, p1 SHALL take the pre-edge value of p2 (value and carry).
REQ-018 On main_clk edge with C2=1, p2 SHALL take next(p1) per REQ-019..REQ-023, evaluated from pre-edge p1.
REQ-019 Priority: LD > SC > INC > DEC > hold.
REQ-020 LD=1: value <= DB; carry <= 0.
REQ-021 SC=1 (LD=0): bits where DB[i]=1 <= SE, other bits <= p1 bit; carry <= p1 carry.
REQ-022 INC=1: value <= p1+1 mod 2^WIDTH; carry <= 1 only when p1 was all-ones (wrap to 0), else 0.
REQ-023 None active: value <= p1 value; carry <= 0.
REQ-024 C1 and C2 both high in one edge: both stages update simultaneously from pre-edge values (swap, no fall-through).
REQ-025 C1=C2=0: both stages hold.
REQ-026 Q = p1 value, CO = p1 carry, combinational from stage registers; latency from C2 update to Q is the next C1 edge.
REQ-027 DB SHALL equal p1 value when OE=1; LD with OE=1 reloads current Q (self-load, no change).
REQ-028 Control inputs (LD, SC, INC, DEC, SE, DB) only matter on edges with C2=1.

Reset
REQ-029 R=1 on any main_clk edge SHALL set p1 and p2 value to RST_VAL and both carries to 0, regardless of C1/C2 or any other input.
REQ-030 Reset mid-count: count restarts from RST_VAL; no carry pulse emitted for the aborted count.
REQ-031 After reset release, Q=RST_VAL and CO=0 until the first C1 edge following a C2 edge.

Configuration
REQ-032 Macro NMOS_CNT_DEC_EN defined: DEC port exists; DEC=1 (LD=SC=INC=0): value <= p1-1 mod 2^WIDTH, carry <= 1 only when p1 was 0 (borrow), else 0; INC=DEC=1 gives INC.
REQ-033 Macro undefined: DEC port absent; decrement logic not compiled; all other behaviour identical.

Verification
REQ-034 R=1 one edge, RST_VAL=8'h5A -> Q=8'h5A, CO=0, DB high-Z with OE=0.
REQ-035 LD=1, DB=8'h3C, C2 edge then C1 edge -> Q=8'h3C after the C1 edge only; unchanged after the C2 edge.
REQ-036 Q=8'hF0, SC=1, SE=0, DB=8'h30, C2 then C1 -> Q=8'hC0; then SE=1, DB=8'h05 -> Q=8'hC5.
REQ-037 Q=8'hFE, INC=1, alternate C2/C1 twice -> Q=8'hFF CO=0, then Q=8'h00 CO=1; third cycle Q=8'h01 CO=0.
REQ-038 NMOS_CNT_DEC_EN defined, Q=8'h00, DEC=1, C2 then C1 -> Q=8'hFF, CO=1; INC=DEC=1 from 8'h10 -> 8'h11.
REQ-039 Counting with C1=C2=1 every edge, R asserted mid-count -> next edge Q=RST_VAL, CO=0; OE=1 drives DB=Q throughout.
